pre_pa_transmit_sequencer: RTL and testbench

//   Transmit-side counterpart of the post-LNA receive chain: takes parallel symbols from the

---
 rtl/pre_pa_transmit_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pre_pa_transmit_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pre_pa_transmit_sequencer.sv
// Pre-PA transmit sequencer: takes parallel symbols from the inner transmit path
// and drives the outer differential pair to the PA. Each frame runs PA ramp-up,
// an alternating preamble, MSB-first serial data and a guard ramp-down. If the
// inner path starves mid-frame, the frame is cut short and an underrun is flagged.
module pre_pa_transmit_sequencer #(
  parameter int unsigned SYMBOL_WIDTH  = 8,
  parameter int unsigned BIT_CYCLES    = 2,
  parameter int unsigned RAMP_CYCLES   = 4,
  parameter int unsigned PREAMBLE_BITS = 4,
  parameter int unsigned GUARD_CYCLES  = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [SYMBOL_WIDTH-1:0] symbol_data_i,
  input  logic                    symbol_valid_i,
  input  logic                    symbol_last_i,
  output logic                    symbol_ready_o,
  output logic                    outer_transmit_p_o,
  output logic                    outer_transmit_n_o,
  output logic                    pa_enable_o,
  output logic                    busy_o,
  output logic                    underrun_o
);

  localparam int unsigned CNT_MAX_BR = (BIT_CYCLES > RAMP_CYCLES) ? BIT_CYCLES : RAMP_CYCLES;
  localparam int unsigned CNT_MAX    = (CNT_MAX_BR > GUARD_CYCLES) ? CNT_MAX_BR : GUARD_CYCLES;
  localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BW = (SYMBOL_WIDTH > 1) ? $clog2(SYMBOL_WIDTH) : 1;
  localparam int unsigned PW = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;

  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] RAMP_LAST  = CW'(RAMP_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [BW-1:0] SYM_LAST   = BW'(SYMBOL_WIDTH - 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(PREAMBLE_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_UP,
    S_PREAMBLE,
    S_DATA,
    S_RAMP_DOWN
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic [SYMBOL_WIDTH-1:0] shift_q, shift_d;
  logic                    last_q, last_d;
  logic                    p_q, p_d;
  logic                    n_q, n_d;
  logic                    pa_q, pa_d;
  logic                    underrun_q, underrun_d;
  logic                    ready;

  // Next-state, handshake and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    pre_d      = pre_q;
    shift_d    = shift_q;
    last_d     = last_q;
    ready      = 1'b0;
    underrun_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (symbol_valid_i) begin
          shift_d = symbol_data_i;
          last_d  = symbol_last_i;
          cyc_d   = '0;
          state_d = S_RAMP_UP;
        end
      end
      S_RAMP_UP: begin
        if (cyc_q == RAMP_LAST) begin
          cyc_d   = '0;
          pre_d   = '0;
          state_d = S_PREAMBLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_PREAMBLE: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (pre_q == PRE_LAST) begin
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (bit_q == SYM_LAST) begin
            bit_d = '0;
            if (last_q) begin
              state_d = S_RAMP_DOWN;
            end else begin
              // Only window where a follow-on symbol can slot in without a bubble.
              ready = 1'b1;
              if (symbol_valid_i) begin
                shift_d = symbol_data_i;
                last_d  = symbol_last_i;
              end else begin
                underrun_d = 1'b1;
                state_d    = S_RAMP_DOWN;
              end
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q << 1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_RAMP_DOWN: begin
        if (cyc_q == GUARD_LAST) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line outputs are derived from the next state so the registered pins line
    // up with the state they belong to; the pair is squelched outside the bit phases.
    p_d = 1'b0;
    n_d = 1'b0;
    if (state_d == S_PREAMBLE) begin
      p_d = ~pre_d[0];
      n_d = pre_d[0];
    end else if (state_d == S_DATA) begin
      p_d = shift_d[SYMBOL_WIDTH-1];
      n_d = ~shift_d[SYMBOL_WIDTH-1];
    end
    pa_d = (state_d != S_IDLE);
  end

  // State, counters, shift register and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst_i) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      pre_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      p_q        <= 1'b0;
      n_q        <= 1'b0;
      pa_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      pre_q      <= pre_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      p_q        <= p_d;
      n_q        <= n_d;
      pa_q       <= pa_d;
      underrun_q <= underrun_d;
    end
  end

  assign symbol_ready_o     = ready;
  assign outer_transmit_p_o = p_q;
  assign outer_transmit_n_o = n_q;
  assign pa_enable_o        = pa_q;
  assign busy_o             = (state_q != S_IDLE);
  assign underrun_o         = underrun_q;

endmodule

// File: tb/tb_pre_pa_transmit_sequencer.sv
// Testbench for pre_pa_transmit_sequencer with default parameters: per-cycle
// vector tables for whole frames, plus hand-written reset and hold-off sequences.
module tb_pre_pa_transmit_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;
  logic       p;
  logic       n;
  logic       pa;
  logic       busy;
  logic       under;

  int n_checks = 0;
  int n_err    = 0;

  // Observed bundle order: {ready, pa_enable, p, n, busy, underrun}
  localparam logic [5:0] IDLE_O = 6'b100000;
  localparam logic [5:0] RAMP_O = 6'b010010;

  typedef struct {
    logic       v;
    logic       l;
    logic [7:0] d;
    logic [5:0] exp;
  } vec_t;

  vec_t tv[$];

  pre_pa_transmit_sequencer dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .symbol_data_i      (data),
    .symbol_valid_i     (valid),
    .symbol_last_i      (last),
    .symbol_ready_o     (ready),
    .outer_transmit_p_o (p),
    .outer_transmit_n_o (n),
    .pa_enable_o        (pa),
    .busy_o             (busy),
    .underrun_o         (under)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Differential legs must never both be high.
  always @(negedge clk) begin
    if (!rst && p && n) begin
      n_err++;
      $display("FAIL pn_both_high at %0t: p=%b n=%b, required not both 1", $time, p, n);
    end
  end

  function automatic logic [5:0] observed();
    return {ready, pa, p, n, busy, under};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {rdy,pa,p,n,busy,und}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic l, input logic [7:0] d, input logic [5:0] exp);
    vec_t e;
    e.v = v; e.l = l; e.d = d; e.exp = exp;
    tv.push_back(e);
  endtask

  task automatic add_idle(input logic v, input logic l, input logic [7:0] d);
    add(v, l, d, IDLE_O);
  endtask

  task automatic add_ramp(input logic v, input logic l, input logic [7:0] d);
    for (int k = 0; k < 4; k++) add(v, l, d, RAMP_O);
  endtask

  task automatic add_preamble(input logic v, input logic l, input logic [7:0] d);
    logic pb;
    for (int b = 0; b < 4; b++) begin
      pb = (b % 2 == 0);
      for (int c = 0; c < 2; c++) add(v, l, d, {1'b0, 1'b1, pb, ~pb, 1'b1, 1'b0});
    end
  endtask

  task automatic add_data(input logic [7:0] sym, input logic v, input logic l,
                          input logic [7:0] d, input logic rdy_final);
    logic pb;
    logic rdy;
    for (int i = 0; i < 8; i++) begin
      pb = sym[7-i];
      for (int c = 0; c < 2; c++) begin
        rdy = rdy_final && (i == 7) && (c == 1);
        add(v, l, d, {rdy, 1'b1, pb, ~pb, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic add_rampdown(input logic und);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 8'h00, {5'b01001, und && (k == 0)});
  endtask

  // Apply each record for one cycle, compare at the falling edge.
  task automatic run_table(input string name);
    for (int i = 0; i < tv.size(); i++) begin
      valid = tv[i].v;
      last  = tv[i].l;
      data  = tv[i].d;
      @(negedge clk);
      check($sformatf("%s[c%0d]", name, i), observed(), tv[i].exp);
      @(posedge clk);
      #1;
    end
    tv.delete();
  endtask

  task automatic cyc(input string name, input logic r, input logic v, input logic l,
                     input logic [7:0] d, input logic chk, input logic [5:0] exp);
    rst = r; valid = v; last = l; data = d;
    @(negedge clk);
    if (chk) check(name, observed(), exp);
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the frame to drain back to IDLE.
  task automatic drain(input string name);
    bit done = 0;
    valid = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check(name, observed(), IDLE_O);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; last = 1'b0; data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_state", observed(), IDLE_O);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single 0xA5 with Last: PaEnable cycles 1..31, preamble 5..12, data 13..28.
    add_idle(1'b1, 1'b1, 8'hA5);
    add_ramp(1'b0, 1'b0, 8'h00);
    add_preamble(1'b0, 1'b0, 8'h00);
    add_data(8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    add_rampdown(1'b0);
    add_idle(1'b0, 1'b0, 8'h00);
    run_table("single_a5");

    // 0xFF then 0x00(Last) held valid throughout: second symbol taken at cycle 28.
    add_idle(1'b1, 1'b0, 8'hFF);
    add_ramp(1'b1, 1'b1, 8'h00);
    add_preamble(1'b1, 1'b1, 8'h00);
    add_data(8'hFF, 1'b1, 1'b1, 8'h00, 1'b1);
    add_data(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    add_rampdown(1'b0);
    add_idle(1'b0, 1'b0, 8'h00);
    run_table("ff_then_00");

    // 0x81 without Last and no follow-on: underrun pulse then guard ramp-down.
    add_idle(1'b1, 1'b0, 8'h81);
    add_ramp(1'b0, 1'b0, 8'h00);
    add_preamble(1'b0, 1'b0, 8'h00);
    add_data(8'h81, 1'b0, 1'b0, 8'h00, 1'b1);
    add_rampdown(1'b1);
    add_idle(1'b0, 1'b0, 8'h00);
    run_table("underrun_81");

    // Reset during preamble discards 0x3C; next frame carries 0xC3.
    cyc("rstpre_c0", 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, IDLE_O);
    for (int k = 1; k <= 4; k++) cyc($sformatf("rstpre_ramp%0d", k), 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, RAMP_O);
    cyc("rstpre_c5", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b011010);
    cyc("rstpre_c6", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 6'b011010);
    cyc("rstpre_idle", 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, IDLE_O);
    cyc("rstpre_new1", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, RAMP_O);
    for (int k = 2; k <= 12; k++) cyc("rstpre_skip", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, IDLE_O);
    cyc("rstpre_new13", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b011010);
    for (int k = 14; k <= 16; k++) cyc("rstpre_skip", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, IDLE_O);
    cyc("rstpre_new17", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b010110);
    drain("rstpre_drain");

    // Valid held through RAMP_DOWN: held off, then starts a new frame from IDLE.
    cyc("hold_c0", 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, IDLE_O);
    for (int k = 1; k <= 28; k++) cyc("hold_skip", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, IDLE_O);
    for (int k = 29; k <= 31; k++) cyc($sformatf("hold_rd%0d", k), 1'b0, 1'b1, 1'b1, 8'h96, 1'b1, RAMP_O);
    cyc("hold_idle32", 1'b0, 1'b1, 1'b1, 8'h96, 1'b1, IDLE_O);
    cyc("hold_new1", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, RAMP_O);
    for (int k = 34; k <= 44; k++) cyc("hold_skip", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, IDLE_O);
    cyc("hold_new13", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b011010);
    cyc("hold_skip", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, IDLE_O);
    cyc("hold_new15", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b010110);
    drain("hold_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
